// File: rtl/bram_dp_be.sv
// Single-clock true dual-port block RAM with per-byte write enables.
// Both ports can read and write. Port A wins any byte that both ports write
// to the same word in the same cycle. A clear engine can zero the whole array
// after reset. An optional second output stage adds one cycle of read latency.
module bram_dp_be #(
    parameter int    ADDR_WIDTH     = 13,
    parameter int    DATA_WIDTH     = 32,
    parameter int    OUT_REG        = 0,
    parameter string WRITE_MODE     = "READ_FIRST",
    parameter int    CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clken_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH/8-1:0] we_a,
    input  logic [DATA_WIDTH-1:0]   data_in_a,
    output logic [DATA_WIDTH-1:0]   data_out_a,
    input  logic                    clken_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    input  logic [DATA_WIDTH/8-1:0] we_b,
    input  logic [DATA_WIDTH-1:0]   data_in_b,
    output logic [DATA_WIDTH-1:0]   data_out_b,
    output logic                    init_busy,
    output logic                    collision
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam bit WRITE_FIRST = (WRITE_MODE == "WRITE_FIRST");
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_nxt_s;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    en_a_s;
    logic                    en_b_s;
    logic                    same_addr_s;
    logic [DATA_WIDTH-1:0]   old_a_s;
    logic [DATA_WIDTH-1:0]   old_b_s;
    logic [DATA_WIDTH-1:0]   fin_a_s;
    logic [DATA_WIDTH-1:0]   fin_b_s;
    logic [DATA_WIDTH-1:0]   rd_a_s;
    logic [DATA_WIDTH-1:0]   rd_b_s;
    logic [DATA_WIDTH-1:0]   rd_a_r;
    logic [DATA_WIDTH-1:0]   rd_b_r;
    logic [DATA_WIDTH-1:0]   out2_a_r;
    logic [DATA_WIDTH-1:0]   out2_b_r;
    logic                    collision_r;

    // Replace the bytes of old_word selected by be with the bytes of new_word.
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BYTES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < BYTES; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Clear engine next state: walk the counter once over the array, then idle.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Clear engine state register; reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Port qualification and read-data selection, including the final merged word.
    always_comb begin
        en_a_s      = clken_a && rst_n && (state_r == ST_IDLE);
        en_b_s      = clken_b && rst_n && (state_r == ST_IDLE);
        same_addr_s = (addr_a == addr_b);
        old_a_s     = mem_r[addr_a];
        old_b_s     = mem_r[addr_b];
        // The word that ends up stored at each port's address: B first, then A on top.
        fin_a_s = (en_b_s && same_addr_s) ? byte_merge(old_a_s, data_in_b, we_b) : old_a_s;
        fin_a_s = en_a_s ? byte_merge(fin_a_s, data_in_a, we_a) : fin_a_s;
        fin_b_s = en_b_s ? byte_merge(old_b_s, data_in_b, we_b) : old_b_s;
        fin_b_s = (en_a_s && same_addr_s) ? byte_merge(fin_b_s, data_in_a, we_a) : fin_b_s;
        // Forwarding applies only when the reading port itself writes.
        if (WRITE_FIRST && (|we_a)) begin
            rd_a_s = fin_a_s;
        end else begin
            rd_a_s = old_a_s;
        end
        if (WRITE_FIRST && (|we_b)) begin
            rd_b_s = fin_b_s;
        end else begin
            rd_b_s = old_b_s;
        end
    end

    // Array writes: clear engine zeroes one word per cycle, else byte writes with A priority.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == ST_CLEAR)) begin
            mem_r[clr_cnt_r] <= '0;
        end else begin
            for (int k = 0; k < BYTES; k++) begin
                if (en_b_s && we_b[k] && !(en_a_s && we_a[k] && same_addr_s)) begin
                    mem_r[addr_b][8*k +: 8] <= data_in_b[8*k +: 8];
                end
                if (en_a_s && we_a[k]) begin
                    mem_r[addr_a][8*k +: 8] <= data_in_a[8*k +: 8];
                end
            end
        end
    end

    // Read output stages and collision flag; everything holds while its port is disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_a_r      <= '0;
            rd_b_r      <= '0;
            out2_a_r    <= '0;
            out2_b_r    <= '0;
            collision_r <= 1'b0;
        end else begin
            if (en_a_s) begin
                rd_a_r   <= rd_a_s;
                out2_a_r <= rd_a_r;
            end
            if (en_b_s) begin
                rd_b_r   <= rd_b_s;
                out2_b_r <= rd_b_r;
            end
            collision_r <= en_a_s && en_b_s && same_addr_s && (|(we_a & we_b));
        end
    end

    assign data_out_a = (OUT_REG != 0) ? out2_a_r : rd_a_r;
    assign data_out_b = (OUT_REG != 0) ? out2_b_r : rd_b_r;
    assign init_busy  = (state_r == ST_CLEAR);
    assign collision  = collision_r;

endmodule

// File: tb/tb_bram_dp_be.sv
// Self-checking bench for bram_dp_be. Two instances share the same stimulus:
// one with latency 1 and READ_FIRST, one with latency 2 and WRITE_FIRST.
// A word-array model with the port-A-wins merge rule predicts every output.
module tb_bram_dp_be;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          clken_a, clken_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [NB-1:0] we_a, we_b;
    logic [DW-1:0] din_a, din_b;

    logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic          busy0, busy1, col0, col1;

    int total;
    int bad;

    // model state
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] e_a0, e_b0, e_a1s, e_b1s, e_a1, e_b1;
    logic          e_col, e_busy;
    int            clr_i;

    bram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0),
                 .WRITE_MODE("READ_FIRST"), .CLEAR_ON_RESET(1)) u_rf (
        .clk(clk), .rst_n(rst_n),
        .clken_a(clken_a), .addr_a(addr_a), .we_a(we_a), .data_in_a(din_a), .data_out_a(dout_a0),
        .clken_b(clken_b), .addr_b(addr_b), .we_b(we_b), .data_in_b(din_b), .data_out_b(dout_b0),
        .init_busy(busy0), .collision(col0)
    );

    bram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1),
                 .WRITE_MODE("WRITE_FIRST"), .CLEAR_ON_RESET(1)) u_wf (
        .clk(clk), .rst_n(rst_n),
        .clken_a(clken_a), .addr_a(addr_a), .we_a(we_a), .data_in_a(din_a), .data_out_a(dout_a1),
        .clken_b(clken_b), .addr_b(addr_b), .we_b(we_b), .data_in_b(din_b), .data_out_b(dout_b1),
        .init_busy(busy1), .collision(col1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] put_bytes(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~m) | (new_w & m);
    endfunction

    // Advance the model by one clock for the currently driven inputs, then clock the DUTs.
    task automatic tick();
        logic [DW-1:0] oa, ob, ra_wf, rb_wf;
        if (!rst_n) begin
            e_a0 = '0; e_b0 = '0; e_a1s = '0; e_b1s = '0; e_a1 = '0; e_b1 = '0;
            e_col = 1'b0; e_busy = 1'b1; clr_i = 0;
        end else if (e_busy) begin
            mm[clr_i] = '0;
            if (clr_i == DEPTH - 1) e_busy = 1'b0;
            else clr_i++;
            e_col = 1'b0;
        end else begin
            oa = mm[addr_a];
            ob = mm[addr_b];
            if (clken_b) mm[addr_b] = put_bytes(mm[addr_b], din_b, we_b);
            if (clken_a) mm[addr_a] = put_bytes(mm[addr_a], din_a, we_a);
            ra_wf = (we_a != 4'h0) ? mm[addr_a] : oa;
            rb_wf = (we_b != 4'h0) ? mm[addr_b] : ob;
            e_col = clken_a && clken_b && (addr_a == addr_b) && ((we_a & we_b) != 4'h0);
            if (clken_a) begin e_a0 = oa; e_a1 = e_a1s; e_a1s = ra_wf; end
            if (clken_b) begin e_b0 = ob; e_b1 = e_b1s; e_b1s = rb_wf; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clken_a = 1'b0; clken_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
        addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        total += 8;
        if (dout_a0 !== 32'h0) begin bad++; $display("FAIL reset_dout_a0 got=%h want=0", dout_a0); end
        if (dout_b0 !== 32'h0) begin bad++; $display("FAIL reset_dout_b0 got=%h want=0", dout_b0); end
        if (dout_a1 !== 32'h0) begin bad++; $display("FAIL reset_dout_a1 got=%h want=0", dout_a1); end
        if (dout_b1 !== 32'h0) begin bad++; $display("FAIL reset_dout_b1 got=%h want=0", dout_b1); end
        if (col0 !== 1'b0) begin bad++; $display("FAIL reset_col0 got=%b want=0", col0); end
        if (col1 !== 1'b0) begin bad++; $display("FAIL reset_col1 got=%b want=0", col1); end
        if (busy0 !== 1'b1) begin bad++; $display("FAIL reset_busy0 got=%b want=1", busy0); end
        if (busy1 !== 1'b1) begin bad++; $display("FAIL reset_busy1 got=%b want=1", busy1); end
        // release and try to write addr 3 while the clear runs
        rst_n = 1'b1;
        clken_a = 1'b1; addr_a = 4'd3; we_a = 4'hF; din_a = 32'hFFFF_FFFF;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            total++;
            if (busy0 !== e_busy || busy1 !== e_busy) begin
                bad++;
                $display("FAIL busy_window cycle=%0d got=%b/%b want=%b", n, busy0, busy1, e_busy);
            end
            if (!busy0) break;
        end
        total++;
        if (n != DEPTH) begin bad++; $display("FAIL busy_length got=%0d want=%0d", n, DEPTH); end
        idle_inputs();
    endtask

    task automatic test_clear_zero();
        clken_a = 1'b1; clken_b = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            addr_a = 4'(i); addr_b = 4'(DEPTH - 1 - i);
            tick();
            total += 3;
            if (dout_a0 !== 32'h0) begin bad++; $display("FAIL clear_a addr=%0d got=%h want=0", i, dout_a0); end
            if (dout_b0 !== 32'h0) begin bad++; $display("FAIL clear_b addr=%0d got=%h want=0", DEPTH - 1 - i, dout_b0); end
            if (dout_a1 !== e_a1) begin bad++; $display("FAIL clear_a1 got=%h want=%h", dout_a1, e_a1); end
        end
        idle_inputs();
    endtask

    task automatic test_byte_write();
        clken_a = 1'b1; addr_a = 4'd5; we_a = 4'hF; din_a = 32'hDEAD_BEEF;
        tick();
        we_a = 4'b0010; din_a = 32'h1122_3344;
        tick();
        clken_a = 1'b0; we_a = 4'h0;
        clken_b = 1'b1; addr_b = 4'd5;
        tick();
        total++;
        if (dout_b0 !== 32'hDEAD_33EF) begin bad++; $display("FAIL byte_we_lat1 got=%h want=deadbeef->dead33ef", dout_b0); end
        tick();
        total++;
        if (dout_b1 !== 32'hDEAD_33EF) begin bad++; $display("FAIL byte_we_lat2 got=%h want=dead33ef", dout_b1); end
        idle_inputs();
    endtask

    task automatic test_collision();
        clken_a = 1'b1; clken_b = 1'b1; addr_a = 4'd7; addr_b = 4'd7;
        din_a = 32'hAAAA_AAAA; we_a = 4'b0011;
        din_b = 32'hBBBB_BBBB; we_b = 4'b0110;
        tick();
        total += 2;
        if (col0 !== 1'b1) begin bad++; $display("FAIL collision_pulse0 got=%b want=1", col0); end
        if (col1 !== 1'b1) begin bad++; $display("FAIL collision_pulse1 got=%b want=1", col1); end
        we_a = 4'h0; we_b = 4'h0;
        tick();
        total += 4;
        if (col0 !== 1'b0) begin bad++; $display("FAIL collision_one_cycle got=%b want=0", col0); end
        if (dout_a0 !== 32'h00BB_AAAA) begin bad++; $display("FAIL collision_word got=%h want=00bbaaaa", dout_a0); end
        if (dout_a1 !== 32'h00BB_AAAA) begin bad++; $display("FAIL collision_wf_a got=%h want=00bbaaaa", dout_a1); end
        if (dout_b1 !== 32'h00BB_AAAA) begin bad++; $display("FAIL collision_wf_b got=%h want=00bbaaaa", dout_b1); end
        we_a = 4'b0011; we_b = 4'b1100;
        tick();
        total += 2;
        if (col0 !== 1'b0) begin bad++; $display("FAIL no_overlap_col0 got=%b want=0", col0); end
        if (col1 !== 1'b0) begin bad++; $display("FAIL no_overlap_col1 got=%b want=0", col1); end
        we_a = 4'h0; we_b = 4'h0;
        tick();
        total++;
        if (dout_b0 !== 32'hBBBB_AAAA) begin bad++; $display("FAIL no_overlap_word got=%h want=bbbbaaaa", dout_b0); end
        idle_inputs();
    endtask

    task automatic test_rdw();
        clken_a = 1'b1; addr_a = 4'd2; we_a = 4'hF; din_a = 32'hCAFE_F00D;
        tick();
        din_a = 32'h1234_5678;
        clken_b = 1'b1; addr_b = 4'd2; we_b = 4'h0;
        tick();
        total += 2;
        if (dout_a0 !== 32'hCAFE_F00D) begin bad++; $display("FAIL rdw_read_first got=%h want=cafef00d", dout_a0); end
        if (dout_b0 !== 32'hCAFE_F00D) begin bad++; $display("FAIL rdw_cross_rf got=%h want=cafef00d", dout_b0); end
        we_a = 4'h0; addr_a = 4'd0; addr_b = 4'd0;
        tick();
        total += 2;
        if (dout_a1 !== 32'h1234_5678) begin bad++; $display("FAIL rdw_write_first got=%h want=12345678", dout_a1); end
        if (dout_b1 !== 32'hCAFE_F00D) begin bad++; $display("FAIL rdw_cross_wf got=%h want=cafef00d", dout_b1); end
        idle_inputs();
    endtask

    task automatic test_clken_hold();
        clken_a = 1'b1; addr_a = 4'd1; we_a = 4'hF; din_a = 32'h55AA_55AA;
        tick();
        we_a = 4'h0;
        tick(); tick();
        clken_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_a = 4'($urandom_range(0, 15));
            we_a   = 4'($urandom_range(1, 15));
            din_a  = $urandom;
            tick();
            total += 2;
            if (dout_a0 !== 32'h55AA_55AA) begin bad++; $display("FAIL hold_lat1 cyc=%0d got=%h want=55aa55aa", i, dout_a0); end
            if (dout_a1 !== 32'h55AA_55AA) begin bad++; $display("FAIL hold_lat2 cyc=%0d got=%h want=55aa55aa", i, dout_a1); end
        end
        idle_inputs();
        clken_b = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            addr_b = 4'(i);
            tick();
            total++;
            if (dout_b0 !== e_b0) begin bad++; $display("FAIL hold_mem addr=%0d got=%h want=%h", i, dout_b0, e_b0); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clken_a = ($urandom_range(0, 3) != 0);
            clken_b = ($urandom_range(0, 3) != 0);
            addr_a  = 4'($urandom_range(0, 15));
            addr_b  = ($urandom_range(0, 1) == 0) ? addr_a : 4'($urandom_range(0, 15));
            we_a    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            we_b    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            din_a   = $urandom;
            din_b   = $urandom;
            tick();
            total += 6;
            if (dout_a0 !== e_a0) begin bad++; $display("FAIL rnd_a0 i=%0d got=%h want=%h", i, dout_a0, e_a0); end
            if (dout_b0 !== e_b0) begin bad++; $display("FAIL rnd_b0 i=%0d got=%h want=%h", i, dout_b0, e_b0); end
            if (dout_a1 !== e_a1) begin bad++; $display("FAIL rnd_a1 i=%0d got=%h want=%h", i, dout_a1, e_a1); end
            if (dout_b1 !== e_b1) begin bad++; $display("FAIL rnd_b1 i=%0d got=%h want=%h", i, dout_b1, e_b1); end
            if (col0 !== e_col) begin bad++; $display("FAIL rnd_col0 i=%0d got=%b want=%b", i, col0, e_col); end
            if (col1 !== e_col) begin bad++; $display("FAIL rnd_col1 i=%0d got=%b want=%b", i, col1, e_col); end
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        int n;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        tick();
        total += 5;
        if (dout_a0 !== 32'h0) begin bad++; $display("FAIL midrst_a0 got=%h want=0", dout_a0); end
        if (dout_b0 !== 32'h0) begin bad++; $display("FAIL midrst_b0 got=%h want=0", dout_b0); end
        if (dout_a1 !== 32'h0) begin bad++; $display("FAIL midrst_a1 got=%h want=0", dout_a1); end
        if (dout_b1 !== 32'h0) begin bad++; $display("FAIL midrst_b1 got=%h want=0", dout_b1); end
        if (busy0 !== 1'b1) begin bad++; $display("FAIL midrst_busy got=%b want=1", busy0); end
        rst_n = 1'b1;
        clken_b = 1'b1; addr_b = 4'd3; we_b = 4'hF; din_b = 32'h0BAD_0BAD;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (!busy0) break;
        end
        total++;
        if (n != DEPTH) begin bad++; $display("FAIL midrst_busy_length got=%0d want=%0d", n, DEPTH); end
        we_b = 4'h0;
        tick();
        total++;
        if (dout_b0 !== 32'h0) begin bad++; $display("FAIL midrst_drop_write got=%h want=0", dout_b0); end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        e_a0 = '0; e_b0 = '0; e_a1s = '0; e_b1s = '0; e_a1 = '0; e_b1 = '0;
        e_col = 1'b0; e_busy = 1'b1; clr_i = 0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_clear_zero();
        test_byte_write();
        test_collision();
        test_rdw();
        test_clken_hold();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_dp_be.md
Name: bram_dp_be

Overview:
- Parametrised single-clock true dual-port block RAM with per-byte write enables.
- Successor to the fixed 32-bit, 8K-word dual-port RAM.
- Adds:
  - generic width and depth,
  - selectable read-during-write mode,
  - optional output pipeline register,
  - hardware clear-on-reset engine,
  - write-collision arbitration and flagging.
- Sits between CPU/DMA masters and on-chip memory in the SoC memory map.

Parameters:
- ADDR_WIDTH, 13, word address bits; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.
- OUT_REG, 0, 0 = read latency 1; 1 = read latency 2 (extra output register).
- WRITE_MODE, "READ_FIRST", same-port read-during-write result: "READ_FIRST" (old data) or "WRITE_FIRST" (merged new data).
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents untouched by reset.

Ports:
- clk  in  1  single clock for both ports.
- rst_n  in  1  synchronous active-low reset.
- clken_a  in  1  port A enable; gates read, write and output register.
- addr_a  in  ADDR_WIDTH  port A word address.
- we_a  in  BYTES  port A byte write enables; bit k covers data bits [8k+7:8k].
- data_in_a  in  DATA_WIDTH  port A write data.
- data_out_a  out  DATA_WIDTH  port A read data.
- clken_b, addr_b, we_b, data_in_b, data_out_b: identical for port B.
- init_busy  out  1  clear engine active; port accesses are ignored.
- collision  out  1  one-cycle pulse: both ports wrote an overlapping byte of the same address.

Behaviour:
- Reset (rst_n sampled low on a clk edge):
  - data_out_a, data_out_b, and output-register stages clear to 0.
  - collision clears to 0.
  - Clear counter clears to 0.
  - init_busy = CLEAR_ON_RESET.
- Clear engine (CLEAR_ON_RESET=1):
  - States are IDLE and CLEAR. Reset forces CLEAR.
  - In CLEAR, one word of zeros is written per cycle at the counter address; the counter increments.
  - After writing word DEPTH-1, go to IDLE and drop init_busy on the next edge. Total = DEPTH cycles after reset release.
  - Counter does not wrap.
  - Reset asserted mid-clear restarts from word 0.
  - While init_busy=1: user writes are dropped, data_out holds 0, collision stays 0, clken is ignored.
- Read, clken=1:
  - OUT_REG=0: data_out = mem[addr] one edge after address sampled.
  - OUT_REG=1: value appears one further edge later.
- Write, clken=1 and we bit k=1: byte k of mem[addr] takes data_in byte k at the edge. Other bytes are unchanged.
- clken=0: no write, no read. data_out and all pipeline stages hold their value.
- Same-port read-during-write:
  - READ_FIRST returns the pre-write word.
  - WRITE_FIRST returns the word with written bytes replaced and unwritten bytes old.
- Cross-port read of an address the other port writes in the same cycle: always returns old data, regardless of WRITE_MODE.
- Both ports write the same address in the same cycle:
  - Per byte, port A wins where both we bits are set.
  - Bytes enabled by only one port are written by that port.
  - collision = 1 on the following cycle iff (we_a & we_b) != 0 and both clken=1; otherwise 0.
  - A same-port WRITE_FIRST read returns the final stored word (A-priority merge).
- Address is compared on the full ADDR_WIDTH; no aliasing.
- Array is inferable block RAM. Arbitration and forwarding live in surrounding logic.

Test Plan:
- Reset, then CLEAR_ON_RESET=1, ADDR_WIDTH=4 → init_busy high exactly 16 cycles after rst_n rises. Writes to addr 3 during busy are dropped. Afterwards every address reads 0x00000000.
- Port A writes 0xDEADBEEF to addr 5 with we_a=4'b1111, then we_a=4'b0010 with 0x11223344 → port B reads 0xDEAD33EF after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- Same-cycle writes to addr 7: A=0xAAAAAAAA with we_a=4'b0011; B=0xBBBBBBBB with we_b=4'b0110 → mem[7]=0x00BBAAAA from cleared state, and collision pulses for 1 cycle. Repeat with we_b=4'b1100 → collision stays 0.
- Port A writes 0x12345678 at addr 2 holding 0xCAFEF00D → data_out_a=0xCAFEF00D (READ_FIRST) or 0x12345678 (WRITE_FIRST). Port B reading addr 2 in the same cycle gets 0xCAFEF00D in both builds.
- Read addr 1 (0x55AA55AA), then clken_a=0 for 3 cycles with address and we toggling → data_out_a stays 0x55AA55AA and memory is unchanged.
- Assert rst_n low for 1 cycle at clear count 9 → data outputs read 0, and init_busy stays high a full DEPTH cycles from the new release.
